// File: rtl/en_capture_reader_if.sv
// Capture/drain bundle for en_capture_reader: write strobe in, valid/ready
// drain out, plus occupancy and drop status.
interface en_capture_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    modport master (
        output enable, data_in, out_ready,
        input  out_valid, out_data, count, full, overflow, drop_cnt
    );

    modport slave (
        input  enable, data_in, out_ready,
        output out_valid, out_data, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/en_capture_reader.sv
// Small circular buffer: words captured on enable, drained in order via
// valid/ready. Writes into a full buffer are dropped and counted.
module en_capture_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    en_capture_reader_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;
    logic w_drop;

    // Full/empty come from the registered count only, so out_valid never
    // sees out_ready combinationally; a read in a full cycle cannot rescue a write.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wr    = bus.enable & ~w_full;
    assign w_drop  = bus.enable &  w_full;
    assign w_rd    = ~w_empty & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Storage is unreset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr) r_mem[r_wr_ptr] <= bus.data_in;
    end

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_en_capture_reader.sv
// Directed + random bench for en_capture_reader against a queue-based model.
module tb_en_capture_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    en_capture_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    en_capture_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: a queue of words plus sticky/drop counters.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    int               m_drops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk({tag, ".data"},  32'(bus.out_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk({tag, ".count"}, 32'(bus.count),     32'(m_q.size()));
        chk({tag, ".full"},  32'(bus.full),      32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".drops"}, 32'(bus.drop_cnt),  32'(m_drops));
    endtask

    // Drive one cycle, update the model across the edge, check on the falling edge.
    task automatic step(input logic rst, input logic en, input logic [WIDTH-1:0] d,
                        input logic rdy, input string tag);
        bit rd, wr;
        rst_n         = ~rst;
        bus.enable    = en;
        bus.data_in   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            rd = (m_q.size() != 0) && rdy;
            wr = en && (m_q.size() < DEPTH);
            if (en && !wr) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        m_ovf   = 1'b0;
        m_drops = 0;
        rst_n = 1'b0; bus.enable = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;

        step(1, 1, 8'h33, 1, "rst0");
        step(1, 0, 8'h00, 0, "rst1");

        // Single word in and out
        step(0, 1, 8'h5A, 0, "single_wr");
        step(0, 0, 8'h00, 1, "single_rd");

        // Fill, overflow, full with read+write, drain
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h10 + i), 0, "fill");
        for (int i = 0; i < 3; i++) step(0, 1, 8'hFF, 0, "ovf");
        step(0, 1, 8'hAA, 1, "full_rdwr");
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, "drain");

        // Streaming across several pointer wraps
        for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 1, "stream");
        step(0, 0, 8'h00, 1, "stream_end");

        // Reset mid-operation with count=3 and overflow set
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h40 + i), 0, "pre_fill");
        step(0, 1, 8'hEE, 0, "pre_drop");
        step(0, 0, 8'h00, 1, "pre_rd");
        step(1, 1, 8'h99, 1, "mid_rst");
        step(0, 1, 8'h77, 0, "post_wr");
        step(0, 0, 8'h00, 1, "post_rd");

        // Drop counter saturation
        for (int i = 0; i < 4; i++) step(0, 1, 8'(i), 0, "sat_fill");
        for (int i = 0; i < 260; i++) step(0, 1, 8'hFF, 0, "sat");
        step(1, 0, 8'h00, 0, "sat_rst");

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), "rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/en_capture_reader.md
EN_CAPTURE_READER -- requirements
Module: en_capture_reader

Interface
REQ-001 Parameter WIDTH, default 8, sets the data word width in bits.
REQ-002 Parameter DEPTH, default 4, sets the number of buffer entries; legal values are powers of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-005 enable  input  1  write strobe; data_in is offered for capture in this cycle.
REQ-006 data_in  input  WIDTH  word to capture.
REQ-007 out_valid  output  1  out_data holds a buffered word.
REQ-008 out_ready  input  1  downstream accepts out_data in this cycle.
REQ-009 out_data  output  WIDTH  oldest buffered word.
REQ-010 count  output  clog2(DEPTH)+1  number of buffered words, 0..DEPTH.
REQ-011 full  output  1  count equals DEPTH.
REQ-012 overflow  output  1  sticky flag: a write was dropped.
REQ-013 drop_cnt  output  8  number of dropped writes, saturating.

Function
REQ-014 The block SHALL be a FIFO reader end: words captured on enable are drained in order through a valid/ready handshake.
REQ-015 A write SHALL be accepted when enable=1 and count<DEPTH at the start of the cycle; the word is stored at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-016 A read SHALL occur when out_valid=1 and out_ready=1; rd_ptr advances modulo DEPTH.
REQ-017 out_valid SHALL equal (count!=0); out_data SHALL equal mem[rd_ptr] when out_valid=1, and 0 otherwise.
REQ-018 Write-to-output latency SHALL be 1 cycle: a word accepted at edge N SHALL be visible on out_data after edge N if the buffer was empty.
REQ-019 count SHALL be incremented by an accepted write and decremented by a read; a simultaneous write and read SHALL leave count unchanged.
REQ-020 When full, enable=1 SHALL be dropped even if a read occurs in the same cycle; storage and wr_ptr stay unchanged.
REQ-021 Every dropped write SHALL set overflow=1 and increment drop_cnt, which saturates at 255.
REQ-022 overflow SHALL remain set until reset.
REQ-023 When empty, out_ready=1 SHALL have no effect on rd_ptr or count; there is no underflow.
REQ-024 Pointer wrap SHALL be seamless: entry DEPTH-1 is followed by entry 0 with no bubble.
REQ-025 out_valid SHALL NOT depend combinationally on out_ready.
REQ-026 A simultaneous write and read with count=1 SHALL present the new word after the edge, with out_valid staying 1.

Reset
REQ-027 With rst_n=0 at a rising edge, the block SHALL clear wr_ptr, rd_ptr, count, overflow and drop_cnt, and force out_valid=0, out_data=0 and full=0.
REQ-028 Reset SHALL take priority over a simultaneous write or read, and SHALL discard all buffered words.
REQ-029 Memory contents SHALL need no reset; they are never observable while count=0.
REQ-030 The first write SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-031 Single word: reset, then enable=1 with data_in=0x5A for one cycle and out_ready=0 -> next cycle out_valid=1, out_data=0x5A, count=1; then out_ready=1 for one cycle -> out_valid=0, out_data=0x00.
REQ-032 Fill and order: write 0x10, 0x11, 0x12, 0x13 with out_ready=0 -> full=1, count=4; then drain with out_ready=1 -> out_data is 0x10, 0x11, 0x12, 0x13 in order, then out_valid=0.
REQ-033 Overflow: with the buffer full, hold enable=1 with data_in=0xFF for 3 cycles while out_ready=0 -> overflow=1, drop_cnt=3, and 0xFF is never output.
REQ-034 Full with simultaneous read and write: with the buffer full, enable=1 with data_in=0xAA and out_ready=1 -> the write is dropped, count=3, drop_cnt increments, and the head word is read.
REQ-035 Wrap and streaming: enable=1 and out_ready=1 every cycle with data_in = 0..19 -> count stays at or below 1, out_data follows data_in with 1-cycle lag, and there are no drops across 5 pointer wraps.
REQ-036 Reset mid-operation: with count=3 and overflow=1, drive rst_n=0 for one edge -> count=0, out_valid=0, overflow=0, drop_cnt=0; then write 0x77 -> 0x77 is the next word output.
